// File: rtl/capture_buffer_ctrl.sv
// capture_buffer_ctrl
// Writes decimated samples for NCH channels into circular sample RAMs with a
// programmable pre-trigger depth. It freezes the buffer once the post-trigger
// window is full, then streams the buffer oldest-first as bytes, either for
// one channel or for all channels in sequence.
module capture_buffer_ctrl #(
   parameter int NCH   = 3,
   parameter int DEPTH = 512,
   parameter int CW    = (NCH > 1) ? $clog2(NCH) : 1,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             smp_en,
   input  logic             trigger,
   input  logic             start_capture,
   input  logic             abort,
   input  logic [AW-1:0]    trig_pos,
   input  logic [3:0]       dec_pwr,
   input  logic             start_dump,
   input  logic [CW-1:0]    dump_chan,
   input  logic             dump_all,
   input  logic             dump_sent,
   input  logic [NCH*8-1:0] rdata,
   output logic             ram_en,
   output logic             ram_we,
   output logic [AW-1:0]    ram_addr,
   output logic [7:0]       dump_data,
   output logic             send_dump,
   output logic             armed,
   output logic             capture_done,
   output logic             dump_done,
   output logic             busy
);

   typedef enum logic [2:0] {
      S_IDLE, S_PRE, S_ARMED, S_POST, S_DONE, S_RD, S_SEND, S_WAIT
   } state_t;

   localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
   localparam logic [CW:0]   NCH_W    = (CW+1)'(NCH);
   localparam logic [CW-1:0] LAST_CH  = CW'(NCH - 1);

   state_t          state_reg, state_next;
   logic [AW-1:0]   wr_ptr_reg, wr_ptr_next;
   logic [AW-1:0]   rd_ptr_reg, rd_ptr_next;
   logic [AW-1:0]   rd_cnt_reg, rd_cnt_next;
   logic [AW:0]     smp_cnt_reg, smp_cnt_next;
   logic [15:0]     dec_cnt_reg, dec_cnt_next;
   logic [AW-1:0]   trig_pos_reg, trig_pos_next;
   logic [3:0]      dec_pwr_reg, dec_pwr_next;
   logic            trig_seen_reg, trig_seen_next;
   logic [CW-1:0]   chan_reg, chan_next;
   logic            dump_all_reg, dump_all_next;
   logic [7:0]      dump_data_reg, dump_data_next;
   logic            send_dump_reg, send_dump_next;
   logic            dump_done_reg, dump_done_next;

   logic [15:0]     dec_mask;
   logic            dec_tick;
   logic [AW:0]     smp_cnt_inc;
   logic [AW:0]     post_len;
   logic [CW-1:0]   chan_sel;
   logic [7:0]      rd_bytes [NCH];

   // Split the packed RAM read bus into one byte per channel.
   for (genvar gi = 0; gi < NCH; gi++) begin : g_unpack
      assign rd_bytes[gi] = rdata[8*gi +: 8];
   end

   assign dec_mask    = ~(16'hFFFF << dec_pwr_reg);
   assign dec_tick    = smp_en & (dec_cnt_reg == dec_mask);
   assign smp_cnt_inc = smp_cnt_reg + 1'b1;
   assign post_len    = DEPTH_W - {1'b0, trig_pos_reg};
   assign chan_sel    = ({1'b0, dump_chan} >= NCH_W) ? LAST_CH : dump_chan;

   assign dump_data    = dump_data_reg;
   assign send_dump    = send_dump_reg;
   assign dump_done    = dump_done_reg;
   assign armed        = (state_reg == S_ARMED);
   assign capture_done = (state_reg == S_DONE) || (state_reg == S_RD) ||
                         (state_reg == S_SEND) || (state_reg == S_WAIT);
   assign busy         = (state_reg != S_IDLE) && (state_reg != S_DONE);

   // Register all state; async reset clears everything to idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= S_IDLE;
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         rd_cnt_reg    <= '0;
         smp_cnt_reg   <= '0;
         dec_cnt_reg   <= '0;
         trig_pos_reg  <= '0;
         dec_pwr_reg   <= '0;
         trig_seen_reg <= 1'b0;
         chan_reg      <= '0;
         dump_all_reg  <= 1'b0;
         dump_data_reg <= '0;
         send_dump_reg <= 1'b0;
         dump_done_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         wr_ptr_reg    <= wr_ptr_next;
         rd_ptr_reg    <= rd_ptr_next;
         rd_cnt_reg    <= rd_cnt_next;
         smp_cnt_reg   <= smp_cnt_next;
         dec_cnt_reg   <= dec_cnt_next;
         trig_pos_reg  <= trig_pos_next;
         dec_pwr_reg   <= dec_pwr_next;
         trig_seen_reg <= trig_seen_next;
         chan_reg      <= chan_next;
         dump_all_reg  <= dump_all_next;
         dump_data_reg <= dump_data_next;
         send_dump_reg <= send_dump_next;
         dump_done_reg <= dump_done_next;
      end
   end

   // Next-state logic, RAM write/read strobes and dump sequencing.
   always_comb begin
      state_next     = state_reg;
      wr_ptr_next    = wr_ptr_reg;
      rd_ptr_next    = rd_ptr_reg;
      rd_cnt_next    = rd_cnt_reg;
      smp_cnt_next   = smp_cnt_reg;
      dec_cnt_next   = dec_cnt_reg;
      trig_pos_next  = trig_pos_reg;
      dec_pwr_next   = dec_pwr_reg;
      trig_seen_next = trig_seen_reg;
      chan_next      = chan_reg;
      dump_all_next  = dump_all_reg;
      dump_data_next = dump_data_reg;
      send_dump_next = 1'b0;
      dump_done_next = 1'b0;
      ram_en         = 1'b0;
      ram_we         = 1'b0;
      ram_addr       = wr_ptr_reg;

      // Decimation counter free-runs on strobes and wraps on each tick.
      if (smp_en) begin
         dec_cnt_next = dec_tick ? 16'd0 : dec_cnt_reg + 16'd1;
      end

      if (abort) begin
         // Abort beats every other input: no write, no send, no done pulse.
         state_next     = S_IDLE;
         trig_seen_next = 1'b0;
      end else begin
         case (state_reg)
            S_IDLE, S_DONE: begin
               if (start_capture) begin
                  trig_pos_next  = trig_pos;
                  dec_pwr_next   = dec_pwr;
                  wr_ptr_next    = '0;
                  dec_cnt_next   = '0;
                  smp_cnt_next   = '0;
                  trig_seen_next = 1'b0;
                  state_next     = (trig_pos == '0) ? S_ARMED : S_PRE;
               end else if ((state_reg == S_DONE) && start_dump) begin
                  // wr_ptr addresses the oldest sample of the frozen buffer.
                  rd_ptr_next   = wr_ptr_reg;
                  rd_cnt_next   = '0;
                  dump_all_next = dump_all;
                  chan_next     = dump_all ? '0 : chan_sel;
                  state_next    = S_RD;
               end
            end
            S_PRE: begin
               if (dec_tick) begin
                  ram_en       = 1'b1;
                  ram_we       = 1'b1;
                  wr_ptr_next  = wr_ptr_reg + 1'b1;
                  smp_cnt_next = smp_cnt_inc;
                  if (smp_cnt_inc == {1'b0, trig_pos_reg}) begin
                     state_next = S_ARMED;
                  end
               end
            end
            S_ARMED: begin
               if (trigger) begin
                  trig_seen_next = 1'b1;
               end
               if (dec_tick) begin
                  ram_en      = 1'b1;
                  ram_we      = 1'b1;
                  wr_ptr_next = wr_ptr_reg + 1'b1;
                  if (trigger || trig_seen_reg) begin
                     // This write is the trigger sample: first of the post window.
                     smp_cnt_next = {{AW{1'b0}}, 1'b1};
                     state_next   = (post_len == {{AW{1'b0}}, 1'b1}) ? S_DONE : S_POST;
                  end
               end
            end
            S_POST: begin
               if (dec_tick) begin
                  ram_en       = 1'b1;
                  ram_we       = 1'b1;
                  wr_ptr_next  = wr_ptr_reg + 1'b1;
                  smp_cnt_next = smp_cnt_inc;
                  if (smp_cnt_inc == post_len) begin
                     state_next = S_DONE;
                  end
               end
            end
            S_RD: begin
               ram_en     = 1'b1;
               ram_addr   = rd_ptr_reg;
               state_next = S_SEND;
            end
            S_SEND: begin
               dump_data_next = rd_bytes[chan_reg];
               send_dump_next = 1'b1;
               state_next     = S_WAIT;
            end
            S_WAIT: begin
               // A sent-pulse coincident with our own request is stale.
               if (dump_sent && !send_dump_reg) begin
                  rd_ptr_next = rd_ptr_reg + 1'b1;
                  rd_cnt_next = rd_cnt_reg + 1'b1;
                  state_next  = S_RD;
                  if (rd_cnt_reg == LAST_IDX) begin
                     if (dump_all_reg && (chan_reg != LAST_CH)) begin
                        chan_next   = chan_reg + 1'b1;
                        rd_cnt_next = '0;
                        rd_ptr_next = wr_ptr_reg;
                     end else begin
                        dump_done_next = 1'b1;
                        state_next     = S_DONE;
                     end
                  end
               end
            end
            default: state_next = S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/capture_buffer_ctrl.md
# capture_buffer_ctrl

Parametrised capture/dump controller for the scope digital core. It writes decimated ADC samples for `NCH` channels into circular sample RAMs, supports a programmable pre-trigger depth, and freezes the buffer once the post-trigger window is full. On command it streams the buffer oldest-first as bytes to the UART response path, either for one channel or for all channels in sequence. It sits between the trigger logic, the channel RAMs and the command handler.

## Interface
- `NCH`, 3: number of channels (≥1); `CW = max(1,$clog2(NCH))`.
- `DEPTH`, 512: samples per channel, power of 2 (≥4); `AW = $clog2(DEPTH)`.
- `clk` in 1: system clock. One clock domain only.
- `rst_n` in 1: asynchronous, active-low reset.
- `smp_en` in 1: ADC sample-valid strobe.
- `trigger` in 1: trigger pulse from the trigger block.
- `start_capture` in 1: arm a new capture; 1-cycle pulse.
- `abort` in 1: force IDLE from any state.
- `trig_pos` in AW: number of pre-trigger samples; legal range 0..DEPTH-1.
- `dec_pwr` in 4: decimation; keep 1 of every 2^dec_pwr strobes.
- `start_dump` in 1: begin dump; 1-cycle pulse.
- `dump_chan` in CW: channel to dump; values ≥NCH are clamped to NCH-1.
- `dump_all` in 1: dump channels 0..NCH-1 in order.
- `dump_sent` in 1: 1-cycle pulse from the UART when a byte has been sent.
- `rdata` in NCH*8: RAM read data, one byte per channel; channel k is at [8k+7:8k].
- `ram_en`, `ram_we` out 1: RAM enable and write enable, common to all RAMs.
- `ram_addr` out AW: RAM address, common to all RAMs.
- `dump_data` out 8: byte being dumped.
- `send_dump` out 1: 1-cycle request to send `dump_data`.
- `armed` out 1: high in ARMED state.
- `capture_done` out 1: high in DONE and dump states.
- `dump_done` out 1: 1-cycle pulse when a dump completes.
- `busy` out 1: high in any state other than IDLE or DONE.

## Operation
- `start_capture` is accepted in IDLE and DONE only; it is ignored elsewhere.
- On acceptance: latch `trig_pos` and `dec_pwr`, clear `wr_ptr`, `dec_cnt` and `smp_cnt`, and clear `trig_seen`.
- Decimation:
  - `dec_tick = smp_en & (dec_cnt == 2^dec_pwr-1)`.
  - `dec_cnt` is 16 bits. It increments on `smp_en` and wraps to 0 on `dec_tick`.
  - With `dec_pwr = 0`, every strobe is a tick.
- States:
  - IDLE: nothing is written.
  - PRE: each `dec_tick` writes one sample and increments `smp_cnt`. Move to ARMED once `smp_cnt == trig_pos`. With `trig_pos = 0`, go directly to ARMED.
  - ARMED: each `dec_tick` writes one sample (circular). A `trigger` pulse sets `trig_seen`.
    - On a `dec_tick` with `trigger | trig_seen`, that sample is the trigger sample. Go to POST with `smp_cnt = 1`.
    - A trigger in PRE is ignored.
  - POST: each `dec_tick` writes one sample and increments `smp_cnt`. After the write where `smp_cnt` reaches `DEPTH - trig_pos`, go to DONE.
  - DONE: the buffer is frozen. `wr_ptr` points at the oldest sample.
  - Dump states RD → SEND → WAIT:
    - `start_dump` is accepted only in DONE. Set `rd_ptr = wr_ptr` and `rd_cnt = 0`. Channel = 0 if `dump_all`, else clamped `dump_chan`.
    - RD: `ram_en = 1`, `ram_addr = rd_ptr`.
    - SEND: latch the selected `rdata` byte into `dump_data`, pulse `send_dump`.
    - WAIT: hold until `dump_sent`, then increment `rd_ptr` (mod DEPTH) and `rd_cnt`.
    - After byte DEPTH of a channel: if `dump_all` and the channel is below NCH-1, advance the channel, reset `rd_cnt`, restore `rd_ptr = wr_ptr`, and go to RD. Otherwise pulse `dump_done` and return to DONE.
- Writes in PRE, ARMED and POST: `ram_en = ram_we = dec_tick`, `ram_addr = wr_ptr`. `wr_ptr` increments mod DEPTH after each write.
- `abort` takes priority over all other inputs. Next state is IDLE, the captured data is discarded, and no `dump_done` is generated.
- The buffer may be dumped repeatedly from DONE.

## Timing
- Reset values:
  - state = IDLE.
  - all pointers, counters and `dump_data` = 0.
  - `ram_en`, `ram_we`, `send_dump`, `dump_done`, `armed`, `capture_done` and `busy` all = 0.
- Capture writes are combinational from registered state plus `dec_tick`, so the write lands in the same cycle as the accepted `smp_en`.
- RAM read latency is 1 cycle. `rdata` is sampled in SEND, the cycle after RD.
- `send_dump` is high for exactly 1 cycle per byte. `dump_data` stays stable from SEND until the next SEND.
- Byte period is at least 3 cycles. A `dump_sent` arriving in the same cycle as `send_dump` is ignored.
- `dump_done` is asserted in the cycle after the final `dump_sent`.
- Total samples per capture are always ≥ DEPTH, so the buffer is full in DONE.

## Test plan
- DEPTH=8, NCH=3, `trig_pos`=3, `dec_pwr`=0, ramp data, `trigger` after 5 ticks → DONE after 5 further writes; single-channel dump emits 8 bytes, oldest first, with the trigger sample as byte 3; `dump_done` pulses once.
- `dec_pwr`=2, `smp_en` every cycle → `ram_we` high every 4th cycle only; write count matches the expected ticks.
- `trig_pos`=0, `trigger` in the same cycle as the first ARMED tick → that sample is dump byte 0; DONE after 8 writes.
- Trigger pulse during PRE is ignored; a trigger between ticks in ARMED is latched via `trig_seen` → the trigger sample is the next tick's sample.
- `dump_all`=1 → 24 bytes in order ch0, ch1, ch2, each channel starting at the same oldest address; `dump_done` follows byte 24 only.
- `abort` mid-dump → IDLE next cycle, no further `send_dump`, no `dump_done`. `start_dump` in IDLE is ignored. Reset mid-capture → all outputs return to 0.
